data_mem_ctrl: RTL and testbench

//  Bridges datapath memory outputs (alu_res address, write_data, mem_ctrl) to a

---
 rtl/data_mem_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns the datapath's load/store request (address,
// store data, mem_ctrl funct3) into a single valid/ready transaction on the
// data-RAM bus. It stalls the core while the transaction is outstanding,
// returns load data aligned to the LSB and flags misaligned/illegal requests
// and bus timeouts.
`timescale 1ns/1ps

module data_mem_ctrl #(
    parameter int unsigned TIMEOUT = 255   // max ACCESS cycles before bus error (1..255)
) (
    input  logic        clk,
    input  logic        reset,
    // request from the datapath
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // response / status to the core
    output logic        stall,
    output logic [31:0] rsp_rdata,
    output logic        misalign,
    output logic        bus_err,
    // data-RAM bus
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    // mem_ctrl encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Last counter value before the timeout fires: the counter starts at 0 on
    // entry to ACCESS, so TIMEOUT ACCESS cycles elapse before the error.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [3:0]  bus_be_q,    bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  off_q,       off_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        bus_err_q,   bus_err_d;

    logic        fault;

    // ------------------------------------------------------------------
    // Request decode helpers
    // ------------------------------------------------------------------

    // Illegal funct3, unaligned halfword/word, or unsigned-flavoured store.
    function automatic logic is_fault(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
        logic f;
        case (f3)
            F3_B, F3_BU: f = 1'b0;
            F3_H, F3_HU: f = off[0];
            F3_W:        f = (off != 2'b00);
            default:     f = 1'b1;
        endcase
        if (we && f3[2]) begin
            f = 1'b1;
        end
        return f;
    endfunction

    // Loads always fetch the whole word; stores enable only their lanes.
    function automatic logic [3:0] lane_be(input logic we, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [3:0] be;
        if (!we) begin
            be = 4'b1111;
        end else begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << off;
                2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Replicate the store datum across every lane so the RAM can pick the
    // enabled one without a shifter; loads drive zeros.
    function automatic logic [31:0] lane_wdata(input logic we, input logic [2:0] f3,
                                               input logic [31:0] d);
        logic [31:0] w;
        if (!we) begin
            w = 32'h0;
        end else begin
            case (f3[1:0])
                2'b00:   w = {4{d[7:0]}};
                2'b01:   w = {2{d[15:0]}};
                default: w = d;
            endcase
        end
        return w;
    endfunction

    // Bring the addressed byte/halfword down to bit 0; extension is done
    // downstream by load_module.
    function automatic logic [31:0] load_align(input logic [31:0] rd,
                                               input logic [1:0] off);
        return rd >> {off, 3'b000};
    endfunction

    assign fault = is_fault(req_we, req_funct3, req_addr[1:0]);

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    assign stall     = ((state_q == S_IDLE) && req_valid && !fault) || (state_q == S_ACCESS);
    assign misalign  = (state_q == S_IDLE) && req_valid && fault;
    assign bus_valid = (state_q == S_ACCESS);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_err   = bus_err_q;

    // Next-state logic: request latch, handshake/timeout resolution, retire.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        off_d       = off_q;
        rsp_rdata_d = rsp_rdata_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !fault) begin
                    bus_we_d    = req_we;
                    bus_addr_d  = {req_addr[31:2], 2'b00};
                    bus_be_d    = lane_be(req_we, req_funct3, req_addr[1:0]);
                    bus_wdata_d = lane_wdata(req_we, req_funct3, req_wdata);
                    off_d       = req_addr[1:0];
                    cnt_d       = 8'd0;
                    state_d     = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // A handshake on the last allowed cycle still counts as success.
                if (bus_ready) begin
                    rsp_rdata_d = bus_we_q ? 32'h0 : load_align(bus_rdata, off_q);
                    bus_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = 32'h0;
                    bus_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_RESP: begin
                // Instruction retires here; req_valid is deliberately ignored.
                bus_err_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bus-field registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
            off_q       <= 2'b00;
            rsp_rdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            off_q       <= off_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: stores, loads with wait states, faults,
// timeout and mid-transaction reset, with hand-computed expectations.
`timescale 1ns/1ps

module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        bus_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_ctrl #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rsp_rdata  (rsp_rdata),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled
    // well after the active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        #1;
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        step();
        reset = 1'b0;
        #1;

        // reset state
        chk("rst_stall",     stall,     0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_we",    bus_we,    0);
        chk("rst_bus_be",    bus_be,    0);
        chk("rst_bus_addr",  bus_addr,  0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_bus_err",   bus_err,   0);
        chk("rst_misalign",  misalign,  0);

        // 1: SW 0x100 zero-wait
        bus_ready = 1'b1;
        drive(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("t1_idle_stall", stall, 1);
        chk("t1_idle_valid", bus_valid, 0);
        step();
        chk("t1_acc_stall", stall, 1);
        chk("t1_acc_valid", bus_valid, 1);
        chk("t1_acc_addr",  bus_addr, 32'h0000_0100);
        chk("t1_acc_be",    bus_be, 4'b1111);
        chk("t1_acc_we",    bus_we, 1);
        chk("t1_acc_wdata", bus_wdata, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("t1_resp_stall", stall, 0);
        chk("t1_resp_valid", bus_valid, 0);
        chk("t1_resp_err",   bus_err, 0);
        chk("t1_resp_rdata", rsp_rdata, 0);
        step();
        chk("t1_idle2_valid", bus_valid, 0);
        chk("t1_idle2_stall", stall, 0);

        // 2: SB 0x103, then SH 0x102
        drive(1'b1, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
        step();
        chk("t2_sb_be",    bus_be, 4'b1000);
        chk("t2_sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        chk("t2_sb_addr",  bus_addr, 32'h0000_0100);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        drive(1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF);
        step();
        chk("t2_sh_be",    bus_be, 4'b1100);
        chk("t2_sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();

        // 3: LHU 0x202 with 3 wait states
        bus_ready = 1'b0;
        bus_rdata = 32'h1234_5678;
        n = 0;
        drive(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0);
        if (stall) n++;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus_ready = 1'b1;
                #1;
            end
            if (stall) n++;
            chk("t3_acc_valid", bus_valid, 1);
            chk("t3_acc_addr",  bus_addr, 32'h0000_0200);
            chk("t3_acc_be",    bus_be, 4'b1111);
            chk("t3_acc_we",    bus_we, 0);
            step();
        end
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus_ready = 1'b0;
        chk("t3_resp_rdata", rsp_rdata, 32'h0000_1234);
        chk("t3_resp_stall", stall, 0);
        chk("t3_stall_cycles", n, 5);
        step();

        // 4: misaligned LW and illegal funct3 / store encodings
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
        chk("t4_lw_mis",   misalign, 1);
        chk("t4_lw_stall", stall, 0);
        chk("t4_lw_valid", bus_valid, 0);
        step();
        chk("t4_lw_valid_next", bus_valid, 0);
        drive(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
        chk("t4_f3_mis",   misalign, 1);
        chk("t4_f3_stall", stall, 0);
        step();
        chk("t4_f3_valid_next", bus_valid, 0);
        drive(1'b1, 1'b1, 3'b100, 32'h0000_0100, 32'h0);
        chk("t4_sbu_mis", misalign, 1);
        drive(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0);
        chk("t4_lh_odd_mis", misalign, 1);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("t4_nomem_stall", stall, 0);
        chk("t4_nomem_mis",   misalign, 0);
        step();

        // 5: timeout with TIMEOUT=4
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus_valid) break;
            n++;
            step();
        end
        chk("t5_access_cycles", n, 4);
        chk("t5_resp_err",   bus_err, 1);
        chk("t5_resp_rdata", rsp_rdata, 0);
        chk("t5_resp_stall", stall, 0);
        step();
        chk("t5_idle_err",   bus_err, 0);
        chk("t5_idle_valid", bus_valid, 0);

        // 6: reset during ACCESS, then a fresh LB
        drive(1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344);
        step();
        chk("t6_acc_valid", bus_valid, 1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", bus_valid, 0);
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_addr",  bus_addr, 0);
        chk("t6_rst_be",    bus_be, 0);
        chk("t6_rst_wdata", bus_wdata, 0);
        chk("t6_rst_we",    bus_we, 0);
        chk("t6_rst_err",   bus_err, 0);
        chk("t6_rst_rdata", rsp_rdata, 0);
        bus_ready = 1'b1;
        bus_rdata = 32'hAABB_CCDD;
        drive(1'b1, 1'b0, 3'b000, 32'h0000_0405, 32'h0);
        chk("t6_new_stall", stall, 1);
        step();
        chk("t6_new_valid", bus_valid, 1);
        chk("t6_new_addr",  bus_addr, 32'h0000_0404);
        chk("t6_new_be",    bus_be, 4'b1111);
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("t6_new_rdata", rsp_rdata, 32'h00AA_BBCC);
        chk("t6_new_err",   bus_err, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
